// File: rtl/spectrum_power_avg.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_power_avg
// Description : Averages |X[k]|^2 over 2^A FFT frames and streams the mean
//               power spectrum out over AXI-Stream.
//               Each input bin's power (re^2 + im^2) is accumulated into a
//               per-bin RAM word. After 2^A frames the block stops accepting
//               input, drains the last RAM write, then dumps word >> A for
//               every bin in order.
// Ports       : ps_clk, ps_aresetn        clock / async active-low reset
//               s_axis_tdata/tvalid/
//               tready/tlast              FFT bins in, {im, re} signed
//               m_axis_tdata/tvalid/
//               tready/tlast              averaged power out, unsigned
//               avg_log2                  averaging exponent (clamped)
//               err_frame / clr_err       sticky tlast/bin mismatch flag
//               peak_bin/val/valid        peak of the last dumped spectrum
// Options     : define SPECTRUM_PEAK_HOLD_EN to build the peak tracker;
//               otherwise the peak outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_power_avg #(
    parameter int FFT_LEN      = 256,
    parameter int DATA_W       = 16,
    parameter int MAX_AVG_LOG2 = 8
) (
    input  logic                        ps_clk,
    input  logic                        ps_aresetn,
    input  logic [2*DATA_W-1:0]         s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [2*DATA_W-1:0]         m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    input  logic [3:0]                  avg_log2,
    output logic                        err_frame,
    input  logic                        clr_err,
    output logic [$clog2(FFT_LEN)-1:0]  peak_bin,
    output logic [2*DATA_W-1:0]         peak_val,
    output logic                        peak_valid
);

    localparam int BIN_W  = $clog2(FFT_LEN);
    localparam int PWR_W  = 2 * DATA_W;
    localparam int ACC_W  = PWR_W + MAX_AVG_LOG2;
    localparam int FCNT_W = MAX_AVG_LOG2 + 1;
    localparam logic [3:0] c_max_avg = 4'(MAX_AVG_LOG2);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    state_t r_state, w_next_state;

    // ------------------------------------------------------------------
    // Power computation: operands widened to PWR_W so that the square of
    // the most negative value (2^(2*DATA_W-2)) and the sum of two such
    // squares (2^(2*DATA_W-1)) are exact.
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] w_re, w_im;
    logic signed [PWR_W-1:0]  w_re_ext, w_im_ext, w_re_sq, w_im_sq;
    logic [PWR_W-1:0]         w_power;

    assign w_re     = $signed(s_axis_tdata[DATA_W-1:0]);
    assign w_im     = $signed(s_axis_tdata[PWR_W-1:DATA_W]);
    assign w_re_ext = PWR_W'(w_re);
    assign w_im_ext = PWR_W'(w_im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_power  = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    // ------------------------------------------------------------------
    // Ingest control
    // ------------------------------------------------------------------
    logic                r_s_tready;
    logic [BIN_W-1:0]    r_bin_cnt;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic [3:0]          r_avg;
    logic                r_err;

    logic                w_accept, w_first_beat, w_last_bin, w_frame_end;
    logic                w_new_err, w_set_done;
    logic [3:0]          w_avg_clamped, w_avg_eff;
    logic [FCNT_W-1:0]   w_frame_target;

    assign w_accept      = s_axis_tvalid && r_s_tready;
    assign w_avg_clamped = (avg_log2 > c_max_avg) ? c_max_avg : avg_log2;
    assign w_first_beat  = (r_frame_cnt == '0) && (r_bin_cnt == '0);
    // The exponent is taken live on the first beat so a single-beat frame
    // can already complete the set with the freshly sampled value.
    assign w_avg_eff      = w_first_beat ? w_avg_clamped : r_avg;
    assign w_last_bin     = (r_bin_cnt == BIN_W'(FFT_LEN - 1));
    assign w_frame_end    = w_accept && (s_axis_tlast || w_last_bin);
    assign w_new_err      = w_accept && (s_axis_tlast != w_last_bin);
    assign w_frame_target = FCNT_W'(1) << w_avg_eff;
    assign w_set_done     = w_frame_end && ((r_frame_cnt + FCNT_W'(1)) == w_frame_target);

    // Stage-1 pipeline register feeding the read-modify-write stage.
    logic                r_p1_valid, r_p1_first;
    logic [BIN_W-1:0]    r_p1_addr;
    logic [PWR_W-1:0]    r_p1_power;

    always_ff @(posedge ps_clk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            r_s_tready  <= 1'b0;
            r_bin_cnt   <= '0;
            r_frame_cnt <= '0;
            r_avg       <= '0;
            r_err       <= 1'b0;
            r_p1_valid  <= 1'b0;
            r_p1_first  <= 1'b0;
            r_p1_addr   <= '0;
            r_p1_power  <= '0;
        end else begin
            // Low for the FLUSH/DUMP states and for one idle cycle after
            // returning to ACCUM.
            r_s_tready <= (r_state == ST_ACCUM) && (w_next_state == ST_ACCUM);
            // A new error wins over a simultaneous clear.
            r_err      <= (r_err && !clr_err) || w_new_err;
            r_p1_valid <= w_accept;
            if (w_accept) begin
                r_p1_first <= (r_frame_cnt == '0);
                r_p1_addr  <= r_bin_cnt;
                r_p1_power <= w_power;
                r_bin_cnt  <= w_frame_end ? '0 : r_bin_cnt + BIN_W'(1);
                if (w_first_beat)
                    r_avg <= w_avg_clamped;
                if (w_set_done)
                    r_frame_cnt <= '0;
                else if (w_frame_end)
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator RAM. Read and write of a bin happen in the same cycle,
    // so back-to-back beats to the same bin (tlast on bin 0) still see
    // the updated word.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] r_acc_ram [FFT_LEN];
    logic [ACC_W-1:0] w_rmw_word;

    assign w_rmw_word = r_p1_first ? ACC_W'(r_p1_power)
                                   : r_acc_ram[r_p1_addr] + ACC_W'(r_p1_power);

    always_ff @(posedge ps_clk) begin
        if (r_p1_valid)
            r_acc_ram[r_p1_addr] <= w_rmw_word;
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    logic r_m_tvalid, r_m_tlast;
    logic w_out_hs, w_dump_done;

    assign w_out_hs    = r_m_tvalid && m_axis_tready;
    assign w_dump_done = w_out_hs && r_m_tlast;

    always_ff @(posedge ps_clk or negedge ps_aresetn) begin
        if (!ps_aresetn)
            r_state <= ST_ACCUM;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCUM: if (w_set_done)  w_next_state = ST_FLUSH;
            ST_FLUSH:                  w_next_state = ST_DUMP;
            ST_DUMP:  if (w_dump_done) w_next_state = ST_ACCUM;
            default:                   w_next_state = ST_ACCUM;
        endcase
    end

    // ------------------------------------------------------------------
    // Dump path: the output register is refilled only when empty or when
    // its current beat is taken, so a stall freezes data, tlast and the
    // read address together.
    // ------------------------------------------------------------------
    logic [BIN_W:0]   r_rd_addr;
    logic [PWR_W-1:0] r_m_tdata;
    logic             w_load;
    logic [PWR_W-1:0] w_out_word;

    assign w_load     = (r_state == ST_DUMP) && (!r_m_tvalid || m_axis_tready)
                        && (r_rd_addr < (BIN_W + 1)'(FFT_LEN));
    assign w_out_word = PWR_W'(r_acc_ram[r_rd_addr[BIN_W-1:0]] >> r_avg);

    always_ff @(posedge ps_clk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            r_rd_addr  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
        end else begin
            if (r_state != ST_DUMP)
                r_rd_addr <= '0;
            else if (w_load)
                r_rd_addr <= r_rd_addr + (BIN_W + 1)'(1);

            if (w_load) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= (r_rd_addr == (BIN_W + 1)'(FFT_LEN - 1));
                r_m_tdata  <= w_out_word;
            end else if (w_out_hs) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdata  = r_m_tdata;
    assign err_frame     = r_err;

    // ------------------------------------------------------------------
    // Peak tracker: strict greater-than keeps the lowest bin on ties.
    // ------------------------------------------------------------------
`ifdef SPECTRUM_PEAK_HOLD_EN
    logic [BIN_W-1:0] r_out_bin, r_run_bin, r_peak_bin;
    logic [PWR_W-1:0] r_run_val, r_peak_val;
    logic             r_peak_valid;
    logic             w_take;

    assign w_take = (r_out_bin == '0) || (r_m_tdata > r_run_val);

    always_ff @(posedge ps_clk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            r_out_bin    <= '0;
            r_run_bin    <= '0;
            r_run_val    <= '0;
            r_peak_bin   <= '0;
            r_peak_val   <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= w_dump_done;
            if (w_load)
                r_out_bin <= r_rd_addr[BIN_W-1:0];
            if (w_out_hs && w_take) begin
                r_run_bin <= r_out_bin;
                r_run_val <= r_m_tdata;
            end
            if (w_dump_done) begin
                r_peak_bin <= w_take ? r_out_bin : r_run_bin;
                r_peak_val <= w_take ? r_m_tdata : r_run_val;
            end
        end
    end

    assign peak_bin   = r_peak_bin;
    assign peak_val   = r_peak_val;
    assign peak_valid = r_peak_valid;
`else
    assign peak_bin   = '0;
    assign peak_val   = '0;
    assign peak_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spectrum_power_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_spectrum_power_avg
// Description : Directed self-checking bench for spectrum_power_avg with
//               FFT_LEN=8, DATA_W=16. Peak checks follow the
//               SPECTRUM_PEAK_HOLD_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spectrum_power_avg;

    localparam int FFT_LEN = 8;
    localparam int DATA_W  = 16;

    logic        ps_clk = 1'b0;
    logic        ps_aresetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [3:0]  avg_log2 = 4'd0;
    logic        err_frame;
    logic        clr_err = 1'b0;
    logic [2:0]  peak_bin;
    logic [31:0] peak_val;
    logic        peak_valid;

    logic [15:0] re_q  [8];
    logic [15:0] im_q  [8];
    logic [31:0] exp_q [8];

    int checks = 0;
    int errors = 0;

    spectrum_power_avg #(.FFT_LEN(FFT_LEN), .DATA_W(DATA_W), .MAX_AVG_LOG2(8)) dut (
        .ps_clk(ps_clk), .ps_aresetn(ps_aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .avg_log2(avg_log2), .err_frame(err_frame), .clr_err(clr_err),
        .peak_bin(peak_bin), .peak_val(peak_val), .peak_valid(peak_valid)
    );

    always #5 ps_clk = ~ps_clk;

    function automatic logic [31:0] pwr(input logic signed [15:0] re, input logic signed [15:0] im);
        longint r = re;
        longint i = im;
        return 32'(r * r + i * i);
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last, input logic clr);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        clr_err       = clr;
        while (!s_axis_tready && n < 50) begin
            @(posedge ps_clk); #1;
            n++;
        end
        if (!s_axis_tready) begin
            checks++; errors++;
            $display("FAIL accept_timeout tready=%0b required 1", s_axis_tready);
        end
        @(posedge ps_clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clr_err       = 1'b0;
    endtask

    // last_at < 0 means no tlast in the frame.
    task automatic send_frame(input int nbeats, input int last_at, input logic clr_last);
        for (int k = 0; k < nbeats; k++)
            send_beat({im_q[k], re_q[k]}, (k == last_at), clr_last && (k == nbeats - 1));
    endtask

    // Collects one dump against exp_q with m_axis_tready following pat
    // (bit n applies on cycle n mod 4), then checks the idle gap and peak.
    task automatic recv_dump(input string name, input logic [3:0] pat);
        int          idx = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        logic [31:0] pk;
        logic [2:0]  pb;
        while (idx < FFT_LEN && cyc < 200) begin
            m_axis_tready = pat[cyc % 4];
            if (m_axis_tvalid) begin
                if (stalled) begin
                    checks++;
                    if (m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
                        errors++;
                        $display("FAIL %s_stall_hold data=%0d last=%0b required data=%0d last=%0b",
                                 name, m_axis_tdata, m_axis_tlast, held_d, held_l);
                    end
                end
                if (m_axis_tready) begin
                    checks++;
                    if (m_axis_tdata !== exp_q[idx] || m_axis_tlast !== (idx == FFT_LEN - 1)) begin
                        errors++;
                        $display("FAIL %s_beat%0d data=%0d last=%0b required data=%0d last=%0b",
                                 name, idx, m_axis_tdata, m_axis_tlast, exp_q[idx], (idx == FFT_LEN - 1));
                    end
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = m_axis_tdata;
                    held_l  = m_axis_tlast;
                end
            end
            @(posedge ps_clk); #1;
            cyc++;
        end
        m_axis_tready = 1'b0;
        if (idx < FFT_LEN) begin
            checks++; errors++;
            $display("FAIL %s_dump_timeout beats=%0d required %0d", name, idx, FFT_LEN);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_dump tvalid=%0b tready=%0b required 0 0", name, m_axis_tvalid, s_axis_tready);
        end
        pk = exp_q[0];
        pb = 3'd0;
        for (int i = 1; i < FFT_LEN; i++)
            if (exp_q[i] > pk) begin
                pk = exp_q[i];
                pb = 3'(i);
            end
`ifdef SPECTRUM_PEAK_HOLD_EN
        checks++;
        if (peak_valid !== 1'b1 || peak_bin !== pb || peak_val !== pk) begin
            errors++;
            $display("FAIL %s_peak valid=%0b bin=%0d val=%0d required 1 %0d %0d",
                     name, peak_valid, peak_bin, peak_val, pb, pk);
        end
`else
        checks++;
        if (peak_valid !== 1'b0 || peak_bin !== 3'd0 || peak_val !== 32'd0) begin
            errors++;
            $display("FAIL %s_peak_tied valid=%0b bin=%0d val=%0d required 0 0 0 (peak %0d@%0d unused)",
                     name, peak_valid, peak_bin, peak_val, pk, pb);
        end
`endif
        @(posedge ps_clk); #1;
        checks++;
        if (s_axis_tready !== 1'b1 || peak_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_resume tready=%0b peak_valid=%0b required 1 0", name, s_axis_tready, peak_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ps_clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tdata !== 32'd0 || err_frame !== 1'b0 || peak_valid !== 1'b0 ||
            peak_bin !== 3'd0 || peak_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs tready=%0b tvalid=%0b tlast=%0b tdata=%0d err=%0b pk=%0b/%0d/%0d required all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, err_frame,
                     peak_valid, peak_bin, peak_val);
        end
        ps_aresetn = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_tready tready=%0b required 0", s_axis_tready);
        end
        @(posedge ps_clk); #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_tready tready=%0b required 1", s_axis_tready);
        end
    endtask

    task automatic test_single_frame();
        avg_log2 = 4'd0;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'd3; im_q[k] = 16'd4; exp_q[k] = 32'd25;
        end
        send_frame(8, 7, 1'b0);
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_flush tready=%0b tvalid=%0b required 0 0", s_axis_tready, m_axis_tvalid);
        end
        @(posedge ps_clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_dump_entry tvalid=%0b required 0", m_axis_tvalid);
        end
        @(posedge ps_clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL single_first_valid tvalid=%0b required 1", m_axis_tvalid);
        end
        recv_dump("single", 4'b1111);
    endtask

    task automatic test_average();
        avg_log2 = 4'd2;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'(k); im_q[k] = 16'd0; exp_q[k] = 32'(k * k);
        end
        send_frame(8, 7, 1'b0);
        avg_log2 = 4'd0;
        for (int f = 1; f < 4; f++)
            send_frame(8, 7, 1'b0);
        recv_dump("average", 4'b1111);
    endtask

    task automatic test_full_scale();
        avg_log2 = 4'd0;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'h8000; im_q[k] = 16'h8000; exp_q[k] = 32'd2147483648;
        end
        send_frame(8, 7, 1'b0);
        recv_dump("full_scale", 4'b1111);
    endtask

    task automatic test_back_to_back();
        avg_log2 = 4'd0;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'(k + 1); im_q[k] = 16'(2 * k);
            exp_q[k] = pwr(re_q[k], im_q[k]);
        end
        send_frame(8, 7, 1'b0);
        recv_dump("backpressure", 4'b1001);
    endtask

    task automatic test_frame_error();
        avg_log2 = 4'd2;
        // Frame powers 1, 4 (short, 5 bins), 9, 16: bins 0-4 sum 30, bins 5-7 sum 26.
        for (int k = 0; k < 8; k++) begin
            im_q[k] = 16'd0;
            exp_q[k] = (k < 5) ? 32'd7 : 32'd6;
        end
        for (int k = 0; k < 8; k++) re_q[k] = 16'd1;
        send_frame(8, 7, 1'b0);
        checks++;
        if (err_frame !== 1'b0) begin
            errors++;
            $display("FAIL err_clean_frame err=%0b required 0", err_frame);
        end
        for (int k = 0; k < 8; k++) re_q[k] = 16'd2;
        send_frame(5, 4, 1'b0);
        checks++;
        if (err_frame !== 1'b1) begin
            errors++;
            $display("FAIL err_early_tlast err=%0b required 1", err_frame);
        end
        clr_err = 1'b1;
        @(posedge ps_clk); #1;
        clr_err = 1'b0;
        checks++;
        if (err_frame !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%0b required 0", err_frame);
        end
        for (int k = 0; k < 8; k++) re_q[k] = 16'd3;
        send_frame(8, -1, 1'b1);
        checks++;
        if (err_frame !== 1'b1) begin
            errors++;
            $display("FAIL err_missing_tlast_with_clr err=%0b required 1", err_frame);
        end
        for (int k = 0; k < 8; k++) re_q[k] = 16'd4;
        send_frame(8, 7, 1'b0);
        recv_dump("frame_error", 4'b1111);
        clr_err = 1'b1;
        @(posedge ps_clk); #1;
        clr_err = 1'b0;
        checks++;
        if (err_frame !== 1'b0) begin
            errors++;
            $display("FAIL err_final_clear err=%0b required 0", err_frame);
        end
    endtask

    task automatic test_clamp();
        avg_log2 = 4'd15;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'(k + 100); im_q[k] = 16'd0;
            exp_q[k] = pwr(re_q[k], im_q[k]);
        end
        for (int f = 0; f < 256; f++)
            send_frame(8, 7, 1'b0);
        recv_dump("clamp", 4'b1111);
    endtask

    task automatic test_reset_mid_dump();
        int n  = 0;
        int hs = 0;
        avg_log2 = 4'd0;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'(k + 1); im_q[k] = 16'(2 * k);
            exp_q[k] = pwr(re_q[k], im_q[k]);
        end
        send_frame(8, 7, 1'b0);
        m_axis_tready = 1'b1;
        while (hs < 3 && n < 50) begin
            if (m_axis_tvalid) hs++;
            @(posedge ps_clk); #1;
            n++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[3]) begin
            errors++;
            $display("FAIL rst_dump_beat4 tvalid=%0b data=%0d required 1 %0d", m_axis_tvalid, m_axis_tdata, exp_q[3]);
        end
        ps_aresetn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tdata !== 32'd0 || err_frame !== 1'b0 || peak_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_dump_outputs tvalid=%0b tready=%0b tlast=%0b tdata=%0d err=%0b pv=%0b required all 0",
                     m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tdata, err_frame, peak_valid);
        end
        m_axis_tready = 1'b0;
        repeat (2) @(posedge ps_clk);
        #1;
        ps_aresetn = 1'b1;
        @(posedge ps_clk); #1;
        for (int k = 0; k < 8; k++) begin
            re_q[k] = 16'd5; im_q[k] = 16'd12; exp_q[k] = 32'd169;
        end
        send_frame(8, 7, 1'b0);
        recv_dump("after_reset", 4'b1111);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_average();
        test_full_scale();
        test_back_to_back();
        test_frame_error();
        test_clamp();
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spectrum_power_avg.md
SPECTRUM_POWER_AVG -- requirements
Module: spectrum_power_avg

Interface
REQ-001 SHALL have parameter FFT_LEN, default 256, bins per frame (power of two, 8..4096).
REQ-002 SHALL have parameter DATA_W, default 16, signed width of each I/Q component.
REQ-003 SHALL have parameter MAX_AVG_LOG2, default 8, largest averaging exponent.
REQ-004 ps_clk  in  1  single clock; all logic on rising edge.
REQ-005 ps_aresetn  in  1  asynchronous active-low reset.
REQ-006 s_axis_tdata  in  2*DATA_W  FFT bin; [DATA_W-1:0]=re, upper half=im, two's complement.
REQ-007 s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1 each  FFT output stream handshake; tlast marks the final bin.
REQ-008 m_axis_tdata  out  2*DATA_W  averaged power, unsigned.
REQ-009 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  averaged spectrum stream to the DMA.
REQ-010 avg_log2  in  4  averaging exponent; values above MAX_AVG_LOG2 clamp to MAX_AVG_LOG2.
REQ-011 err_frame  out  1  sticky flag for tlast/bin-count mismatch; cleared by clr_err.
REQ-012 clr_err  in  1  single-cycle pulse that clears err_frame.
REQ-013 peak_bin / peak_val / peak_valid  out  log2(FFT_LEN) / 2*DATA_W / 1  peak report (see REQ-031).

Function
REQ-014 Each accepted beat: power = re*re + im*im, an exact unsigned value of 2*DATA_W bits that SHALL NOT overflow.
REQ-015 Accumulator RAM: FFT_LEN words of 2*DATA_W+MAX_AVG_LOG2 bits; read-modify-write pipeline of 2 stages.
  - Frame 0 of a set writes power, overwriting the stored word.
  - Later frames write stored word + power.
REQ-016 FSM states SHALL be ACCUM, FLUSH, DUMP.
  - ACCUM: s_axis_tready=1, m_axis_tvalid=0.
  - FLUSH: one cycle, tready=0, lets the final write retire.
  - DUMP: tready=0, streams FFT_LEN beats.
REQ-017 avg_log2 SHALL be sampled (A) on the first accepted beat of each averaging set and held for the whole set.
REQ-018 The bin counter SHALL increment per accepted beat and return to 0 on tlast or after bin FFT_LEN-1, whichever comes first.
REQ-019 tlast on a bin other than FFT_LEN-1, or no tlast on bin FFT_LEN-1, SHALL set err_frame; the frame still counts as complete.
REQ-020 When 2^A frames have completed: ACCUM->FLUSH->DUMP.
REQ-021 DUMP: m_axis_tdata = stored word >> A, for bins 0..FFT_LEN-1 in order.
  - m_axis_tlast=1 on bin FFT_LEN-1 only.
  - First m_axis_tvalid SHALL occur 1 cycle after entering DUMP.
REQ-022 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable; the RAM read address advances only on a handshake.
REQ-023 After the tlast handshake: DUMP->ACCUM, frame count 0, at least 1 idle cycle with tready=0.
REQ-024 If clr_err and a new error occur in the same cycle, err_frame SHALL read 1.

Reset
REQ-025 On ps_aresetn=0, at any time including mid-DUMP, outputs SHALL go immediately to: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, err_frame=0, peak_*=0.
REQ-026 Reset SHALL set state=ACCUM, bin counter=0, frame count=0.
REQ-027 s_axis_tready SHALL rise on the first clock edge after reset release; RAM contents are don't-care, since frame 0 overwrites them.

Configuration
REQ-028 Macro SPECTRUM_PEAK_HOLD_EN SHALL compile the peak tracker in or out.
REQ-029 Tracker: during DUMP, keep the largest output value; on ties, keep the lowest bin.
REQ-030 Without the macro, peak_bin, peak_val and peak_valid SHALL be tied to 0 and the tracker SHALL add no logic.
REQ-031 With the macro, peak_valid SHALL pulse for 1 cycle on the cycle after the DUMP tlast handshake, with peak_bin/peak_val valid and held until the next pulse.

Verification (FFT_LEN=8, DATA_W=16)
REQ-032 A=0, one frame with re=3, im=4 on all bins -> 8 beats of 25, tlast on beat 8.
REQ-033 A=2, 4 frames with bin k: re=k, im=0 -> output k*k for k=0..7; avg_log2 changed to 0 mid-set has no effect.
REQ-034 re=im=-32768, A=0 -> all outputs 2147483648, no wrap; with macro, peak_bin=0, peak_valid pulses once.
REQ-035 m_axis_tready toggling 1,0,0,1 -> 8 ordered beats, data stable during stalls, no loss or duplication.
REQ-036 tlast on beat 5 of 8 -> err_frame=1 and the next frame starts at bin 0; clr_err -> err_frame=0.
REQ-037 Reset asserted during beat 4 of DUMP -> m_axis_tvalid=0 immediately; after release a fresh A=0 frame dumps correctly.
